// File: rtl/board_monitor.sv
// Life-board generation monitor: counts population, detects still/period-2/extinct boards, requests halt.
// Latency: flags, population and gen_done register 1 cycle after the row-7 write edge.
// Backpressure: none; every wr_en edge is accepted, and an out-of-order row aborts the sweep with seq_err.
module board_monitor #(
    parameter int WIDTH     = 8,
    parameter int REGBITS   = 3,
    parameter int HOLD_GENS = 4
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [REGBITS-1:0] addr,
    input  logic [WIDTH-1:0]   new_r,
    input  logic [WIDTH-1:0]   old_r,
    output logic               gen_done,
    output logic [6:0]         population,
    output logic [15:0]        generation,
    output logic               extinct,
    output logic               still,
    output logic               osc2,
    output logic               halt,
    output logic               seq_err
);

    localparam int         ROWS     = 1 << REGBITS;
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_GENS);

    logic [REGBITS-1:0] exp_row;
    logic [6:0]         sum;
    logic               chg_ok;
    logic               osc_ok;
    logic               hist_valid;
    logic [3:0]         stall_cnt;
    logic [WIDTH-1:0]   hist [ROWS];

    logic [6:0] row_pop;
    logic       in_order;
    logic       row_zero;
    logic       take;
    logic       last;
    logic [6:0] acc_sum;
    logic       acc_chg;
    logic       acc_osc;
    logic       sweep_ext;
    logic       sweep_osc2;
    logic [3:0] stall_nx;

    always_comb begin
        row_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row_pop = row_pop + {6'b0, new_r[i]};
        end
    end

    // A row-0 write always opens a fresh sweep, whether or not it was the expected row.
    always_comb begin
        in_order   = (addr == exp_row);
        row_zero   = (addr == '0);
        take       = wr_en & (in_order | row_zero);
        last       = take & ~row_zero & (addr == '1);
        acc_sum    = row_zero ? row_pop : sum + row_pop;
        acc_chg    = (row_zero | chg_ok) & (new_r == old_r);
        acc_osc    = (row_zero | osc_ok) & (new_r == hist[addr]);
        sweep_ext  = (acc_sum == '0);
        sweep_osc2 = acc_osc & hist_valid & ~acc_chg;
        if (sweep_ext | acc_chg | sweep_osc2) begin
            stall_nx = (stall_cnt == 4'hF) ? 4'hF : stall_cnt + 4'd1;
        end else begin
            stall_nx = '0;
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            exp_row    <= '0;
            sum        <= '0;
            chg_ok     <= 1'b0;
            osc_ok     <= 1'b0;
            hist_valid <= 1'b0;
            stall_cnt  <= '0;
            for (int r = 0; r < ROWS; r++) begin
                hist[r] <= '0;
            end
            gen_done   <= 1'b0;
            seq_err    <= 1'b0;
            population <= '0;
            generation <= '0;
            extinct    <= 1'b0;
            still      <= 1'b0;
            osc2       <= 1'b0;
            halt       <= 1'b0;
        end else begin
            gen_done <= last;
            seq_err  <= wr_en & ~in_order;
            if (take) begin
                sum           <= acc_sum;
                chg_ok        <= acc_chg;
                osc_ok        <= acc_osc;
                hist[addr]    <= old_r;
                exp_row       <= addr + 1'b1;
            end else if (wr_en) begin
                exp_row <= '0;
            end
            if (last) begin
                population <= acc_sum;
                extinct    <= sweep_ext;
                still      <= acc_chg;
                osc2       <= sweep_osc2;
                hist_valid <= 1'b1;
                if (generation != 16'hFFFF) begin
                    generation <= generation + 16'd1;
                end
                stall_cnt <= stall_nx;
                if (stall_nx >= HOLD_LIM) begin
                    halt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_monitor.sv
// Directed bench for board_monitor: hand-computed sweeps, blinker, abort, reset and saturation cases.
module tb_board_monitor;

    logic        ph1;
    logic        reset;
    logic        wr_en;
    logic [2:0]  addr;
    logic [7:0]  new_r;
    logic [7:0]  old_r;
    logic        gen_done;
    logic [6:0]  population;
    logic [15:0] generation;
    logic        extinct;
    logic        still;
    logic        osc2;
    logic        halt;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] nr   [8];
    logic [7:0] orow [8];

    board_monitor #(.WIDTH(8), .REGBITS(3), .HOLD_GENS(4)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .wr_en      (wr_en),
        .addr       (addr),
        .new_r      (new_r),
        .old_r      (old_r),
        .gen_done   (gen_done),
        .population (population),
        .generation (generation),
        .extinct    (extinct),
        .still      (still),
        .osc2       (osc2),
        .halt       (halt),
        .seq_err    (seq_err)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] n, input logic [7:0] o);
        wr_en = 1'b1;
        addr  = a;
        new_r = n;
        old_r = o;
        @(posedge ph1);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        @(posedge ph1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        @(posedge ph1);
        #1;
        reset = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), nr[i], orow[i]);
        end
        wr_en = 1'b0;
    endtask

    task automatic fill(input logic [7:0] n, input logic [7:0] o);
        for (int i = 0; i < 8; i++) begin
            nr[i]   = n;
            orow[i] = o;
        end
    endtask

    // Vertical blinker: rows 2..4 = 08; horizontal: row 3 = 1C.
    task automatic set_blink(input bit horiz_new);
        fill(8'h00, 8'h00);
        if (horiz_new) begin
            nr[3]   = 8'h1C;
            orow[2] = 8'h08;
            orow[3] = 8'h08;
            orow[4] = 8'h08;
        end else begin
            orow[3] = 8'h1C;
            nr[2]   = 8'h08;
            nr[3]   = 8'h08;
            nr[4]   = 8'h08;
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_pop"},  32'(population), 32'd0);
        chk({pfx, "_gen"},  32'(generation), 32'd0);
        chk({pfx, "_ext"},  32'(extinct),    32'd0);
        chk({pfx, "_still"}, 32'(still),     32'd0);
        chk({pfx, "_osc2"}, 32'(osc2),       32'd0);
        chk({pfx, "_halt"}, 32'(halt),       32'd0);
        chk({pfx, "_done"}, 32'(gen_done),   32'd0);
        chk({pfx, "_serr"}, 32'(seq_err),    32'd0);
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        new_r = '0;
        old_r = '0;
        @(negedge ph1);

        // Empty board sweep.
        do_reset();
        chk_all_zero("rst");
        fill(8'h00, 8'h00);
        sweep();
        chk("z_done", 32'(gen_done),   32'd1);
        chk("z_pop",  32'(population), 32'd0);
        chk("z_ext",  32'(extinct),    32'd1);
        chk("z_still", 32'(still),     32'd1);
        chk("z_osc2", 32'(osc2),       32'd0);
        chk("z_gen",  32'(generation), 32'd1);
        idle();
        chk("z_done_clr", 32'(gen_done), 32'd0);
        chk("z_ext_hold", 32'(extinct),  32'd1);

        // Blinker: osc2 from sweep 2 on, halt after sweep 5.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            set_blink(k % 2 == 1);
            sweep();
            chk($sformatf("bl%0d_done", k), 32'(gen_done),   32'd1);
            chk($sformatf("bl%0d_pop", k),  32'(population), 32'd3);
            chk($sformatf("bl%0d_still", k), 32'(still),     32'd0);
            chk($sformatf("bl%0d_osc2", k), 32'(osc2),       (k == 1) ? 32'd0 : 32'd1);
            chk($sformatf("bl%0d_halt", k), 32'(halt),       (k >= 5) ? 32'd1 : 32'd0);
        end
        idle();
        chk("bl_halt_sticky", 32'(halt), 32'd1);

        // Aborted sweep: rows 0,1,2,5.
        do_reset();
        fill(8'h00, 8'h00);
        sweep();
        wr(3'd0, 8'h00, 8'h00);
        wr(3'd1, 8'h00, 8'h00);
        wr(3'd2, 8'h00, 8'h00);
        chk("ab_serr_pre", 32'(seq_err), 32'd0);
        wr(3'd5, 8'h00, 8'h00);
        chk("ab_serr",  32'(seq_err),  32'd1);
        chk("ab_done",  32'(gen_done), 32'd0);
        idle();
        chk("ab_serr_clr", 32'(seq_err),    32'd0);
        chk("ab_gen",      32'(generation), 32'd1);
        fill(8'h81, 8'h81);
        sweep();
        chk("ab_re_done", 32'(gen_done),   32'd1);
        chk("ab_re_gen",  32'(generation), 32'd2);
        chk("ab_re_pop",  32'(population), 32'd16);

        // Full board.
        do_reset();
        fill(8'hFF, 8'h00);
        sweep();
        chk("full_pop",   32'(population), 32'h40);
        chk("full_still", 32'(still),      32'd0);
        chk("full_ext",   32'(extinct),    32'd0);
        chk("full_osc2",  32'(osc2),       32'd0);

        // Reset on the row-4 edge, then rows 5..7 with no row 0.
        for (int i = 0; i < 4; i++) begin
            wr(3'(i), 8'hFF, 8'h00);
        end
        reset = 1'b1;
        wr(3'd4, 8'hFF, 8'h00);
        reset = 1'b0;
        wr_en = 1'b0;
        chk_all_zero("mr");
        wr(3'd5, 8'hFF, 8'h00);
        chk("mr_serr5", 32'(seq_err), 32'd1);
        wr(3'd6, 8'hFF, 8'h00);
        chk("mr_serr6", 32'(seq_err), 32'd1);
        wr(3'd7, 8'hFF, 8'h00);
        chk("mr_done7", 32'(gen_done), 32'd0);
        idle();
        chk("mr_done_idle", 32'(gen_done),   32'd0);
        chk("mr_gen",       32'(generation), 32'd0);

        // Saturation: preload the counter instead of running ~65k sweeps.
        do_reset();
        force dut.generation = 16'hFFFE;
        @(negedge ph1);
        release dut.generation;
        fill(8'h01, 8'h02);
        for (int k = 1; k <= 3; k++) begin
            sweep();
            chk($sformatf("sat%0d_gen", k), 32'(generation), 32'hFFFF);
        end
        chk("sat_pop", 32'(population), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
